// File: rtl/agu_issue_queue_param_pkg.sv
// Shared types for the AGU issue queue.
// Contents:
//   AGU_DATA_W / AGU_TAG_W  widest operand and tag the entry storage holds
//   agu_entry_t             one reservation slot (payload plus operand valid bits)
//   entry_src_e             next-state source chosen by the top for each slot
//   tag_match()             CDB wakeup condition for one operand
package agu_queue_pkg;

  localparam int AGU_DATA_W = 32;
  localparam int AGU_TAG_W  = 6;

  typedef struct packed {
    logic                  valid;
    logic [AGU_DATA_W-1:0] op1_data;
    logic [AGU_TAG_W-1:0]  op1_tag;
    logic                  op1_vld;
    logic [AGU_DATA_W-1:0] op2_data;
    logic [AGU_TAG_W-1:0]  op2_tag;
    logic                  op2_vld;
    logic [AGU_TAG_W-1:0]  rd_tag;
    logic                  rd_vld;
    logic [2:0]            funct3;
    logic                  ls;
    logic [AGU_DATA_W-1:0] imm;
  } agu_entry_t;

  // HOLD keeps the slot, ABOVE collapses the next-younger slot down,
  // DISP writes the newly dispatched op.
  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_ABOVE = 2'd1,
    SRC_DISP  = 2'd2
  } entry_src_e;

  // An operand wakes when it is still waiting and the CDB carries its tag.
  function automatic logic tag_match(input logic                 vld,
                                     input logic                 cdb_valid,
                                     input logic [AGU_TAG_W-1:0] tag,
                                     input logic [AGU_TAG_W-1:0] cdb_tag);
    return !vld && cdb_valid && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/agu_issue_queue_param_if.sv
// Dispatch / CDB / issue bundle between the rename stage, the AGU and the queue.
// master: drives flush, disp_*, cdb_*, iss_ready; observes iss_*, full, empty, count
// slave : the queue itself (mirror of master)
interface agu_iq_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_op1_data;
  logic [TAG_W-1:0]  disp_op1_tag;
  logic              disp_op1_vld;
  logic [DATA_W-1:0] disp_op2_data;
  logic [TAG_W-1:0]  disp_op2_tag;
  logic              disp_op2_vld;
  logic [TAG_W-1:0]  disp_rd_tag;
  logic              disp_rd_vld;
  logic [2:0]        disp_funct3;
  logic              disp_ls;
  logic [DATA_W-1:0] disp_imm;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_ready;
  logic              iss_valid;
  logic [DATA_W-1:0] iss_op1;
  logic [DATA_W-1:0] iss_op2;
  logic [DATA_W-1:0] iss_imm;
  logic [TAG_W-1:0]  iss_rd_tag;
  logic              iss_rd_vld;
  logic              iss_ls;
  logic [2:0]        iss_funct3;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, disp_valid, disp_op1_data, disp_op1_tag, disp_op1_vld,
           disp_op2_data, disp_op2_tag, disp_op2_vld, disp_rd_tag, disp_rd_vld,
           disp_funct3, disp_ls, disp_imm, cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  iss_valid, iss_op1, iss_op2, iss_imm, iss_rd_tag, iss_rd_vld, iss_ls,
           iss_funct3, full, empty, count
  );

  modport slave (
    input  flush, disp_valid, disp_op1_data, disp_op1_tag, disp_op1_vld,
           disp_op2_data, disp_op2_tag, disp_op2_vld, disp_rd_tag, disp_rd_vld,
           disp_funct3, disp_ls, disp_imm, cdb_valid, cdb_tag, cdb_data, iss_ready,
    output iss_valid, iss_op1, iss_op2, iss_imm, iss_rd_tag, iss_rd_vld, iss_ls,
           iss_funct3, full, empty, count
  );
endinterface

// File: rtl/agu_issue_queue_param_entry.sv
// One reservation slot of the AGU issue queue.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush_i          clears the slot (wins over everything else)
//   src_i            next-state source: hold / collapse from above / dispatch write
//   above_i          contents of the next-younger slot
//   disp_i           newly dispatched op
//   cdb_*_i          result broadcast used for operand wakeup
//   entry_o, rdy_o   registered slot contents and issue readiness
module agu_queue_entry
  import agu_queue_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  entry_src_e            src_i,
  input  agu_entry_t            above_i,
  input  agu_entry_t            disp_i,
  input  logic                  cdb_valid_i,
  input  logic [AGU_TAG_W-1:0]  cdb_tag_i,
  input  logic [AGU_DATA_W-1:0] cdb_data_i,
  output agu_entry_t            entry_o,
  output logic                  rdy_o
);

  agu_entry_t entry_q, entry_d, base;

  // Wakeup is applied after the source mux, so a slot collapsing down or a
  // freshly dispatched op still captures a same-cycle CDB broadcast.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    base = entry_q;
    unique case (src_i)
      SRC_ABOVE: base = above_i;
      SRC_DISP:  base = disp_i;
      default:   base = entry_q;
    endcase

    entry_d = base;
    if (base.valid && tag_match(base.op1_vld, cdb_valid_i, base.op1_tag, cdb_tag_i)) begin
      entry_d.op1_data = cdb_data_i;
      entry_d.op1_vld  = 1'b1;
    end
    if (base.valid && tag_match(base.op2_vld, cdb_valid_i, base.op2_tag, cdb_tag_i)) begin
      entry_d.op2_data = cdb_data_i;
      entry_d.op2_vld  = 1'b1;
    end
    if (flush_i) entry_d.valid = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: only the valid bit is reset; payload is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) entry_q.valid <= 1'b0;
    else     entry_q       <= entry_d;
  end

  assign entry_o = entry_q;
  assign rdy_o   = entry_q.valid & entry_q.op1_vld & entry_q.op2_vld;

endmodule

// File: rtl/agu_issue_queue_param.sv
// DEPTH-entry collapsing reservation queue in front of the AGU.
// Accepts dispatched ld/st ops, wakes operands from the CDB by tag and issues
// one ready op per cycle (oldest-ready for MODE 0, head-only for MODE 1).
// Slot 0 is always the oldest entry; popping collapses younger entries down.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       agu_iq_if.slave: flush, dispatch, CDB, issue handshake, full/empty/count
// DATA_W/TAG_W may not exceed AGU_DATA_W/AGU_TAG_W; entries store zero-extended values.
module agu_issue_queue_param
  import agu_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = AGU_DATA_W,
  parameter int TAG_W  = AGU_TAG_W,
  parameter int MODE   = 0
) (
  input logic     clk,
  input logic     rst,
  agu_iq_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  agu_entry_t           entries [DEPTH];
  agu_entry_t           above   [DEPTH];
  entry_src_e           src     [DEPTH];
  logic [DEPTH-1:0]     rdy;
  agu_entry_t           disp_e;
  agu_entry_t           sel_e;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic                 pop, accept;
  logic [CNT_W-1:0]     count_q, count_d, disp_slot;
  logic                 full_q, empty_q;

  always_comb begin
    disp_e          = '0;
    disp_e.valid    = 1'b1;
    disp_e.op1_data = AGU_DATA_W'(bus.disp_op1_data);
    disp_e.op1_tag  = AGU_TAG_W'(bus.disp_op1_tag);
    disp_e.op1_vld  = bus.disp_op1_vld;
    disp_e.op2_data = AGU_DATA_W'(bus.disp_op2_data);
    disp_e.op2_tag  = AGU_TAG_W'(bus.disp_op2_tag);
    disp_e.op2_vld  = bus.disp_op2_vld;
    disp_e.rd_tag   = AGU_TAG_W'(bus.disp_rd_tag);
    disp_e.rd_vld   = bus.disp_rd_vld;
    disp_e.funct3   = bus.disp_funct3;
    disp_e.ls       = bus.disp_ls;
    disp_e.imm      = AGU_DATA_W'(bus.disp_imm);
  end

  // Select from registered readiness only, so wakeups take effect next cycle.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (MODE == 1) begin
      sel_valid = rdy[0];
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (rdy[i]) begin
          sel_valid = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Full is the registered flag: a full queue refuses dispatch even while popping.
  assign pop       = sel_valid & bus.iss_ready & ~bus.flush;
  assign accept    = bus.disp_valid & ~full_q & ~bus.flush;
  assign disp_slot = count_q - CNT_W'(pop);
  assign count_d   = bus.flush ? '0 : count_q + CNT_W'(accept) - CNT_W'(pop);

  // Slots at or above the popped index collapse down; the dispatch slot is
  // count - pop, which after a pop is the one vacated by the collapse.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src[i] = SRC_HOLD;
      if (pop && (IDX_W'(i) >= sel_idx))
        src[i] = (accept && (CNT_W'(i) == disp_slot)) ? SRC_DISP : SRC_ABOVE;
      else if (accept && (CNT_W'(i) == disp_slot))
        src[i] = SRC_DISP;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g == DEPTH - 1) begin : g_top
      assign above[g] = '0;
    end else begin : g_mid
      assign above[g] = entries[g+1];
    end

    agu_queue_entry u_entry (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (bus.flush),
      .src_i       (src[g]),
      .above_i     (above[g]),
      .disp_i      (disp_e),
      .cdb_valid_i (bus.cdb_valid),
      .cdb_tag_i   (AGU_TAG_W'(bus.cdb_tag)),
      .cdb_data_i  (AGU_DATA_W'(bus.cdb_data)),
      .entry_o     (entries[g]),
      .rdy_o       (rdy[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign sel_e = entries[sel_idx];

  assign bus.iss_valid  = sel_valid;
  assign bus.iss_op1    = DATA_W'(sel_e.op1_data);
  assign bus.iss_op2    = DATA_W'(sel_e.op2_data);
  assign bus.iss_imm    = DATA_W'(sel_e.imm);
  assign bus.iss_rd_tag = TAG_W'(sel_e.rd_tag);
  assign bus.iss_rd_vld = sel_e.rd_vld;
  assign bus.iss_ls     = sel_e.ls;
  assign bus.iss_funct3 = sel_e.funct3;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.count      = count_q;

endmodule
